eth_mdio_responder: RTL
=======================

Name: eth_mdio_responder

Overview:
- Clause-22 MDIO management responder (PHY side) for the Ethernet management pins (mdc/md_o/md_oe toward pad, md_i from pad).
- Oversamples MDC in the SoC clock domain, decodes read/write frames addressed to its PHY address, and bridges them onto a simple local register port.
- Used as a synthesizable PHY-management stand-in on FPGA targets and as the responder end in SoC-level MDIO tests.

Parameters:
- SyncStages, 3, number of synchronizer flops on mdc_i and mdio_i (minimum 2).
- PreambleLen, 32, consecutive '1' bits required before ST (range 1..32).

Ports:
- clk_i  in  1  SoC clock; must run at least 8x MDC.
- rst_i  in  1  asynchronous reset, active-high.
- phy_addr_i  in  5  strapped PHY address; quasi-static.
- mdc_i  in  1  management clock from the MAC (asynchronous).
- mdio_i  in  1  MDIO line as seen at the pad.
- mdio_o  out  1  MDIO drive value.
- mdio_oe_o  out  1  MDIO output enable (1 = drive).
- wr_valid_o  out  1  one-cycle write strobe.
- wr_addr_o  out  5  register address of the write.
- wr_data_o  out  16  write data.
- rd_req_o  out  1  one-cycle read request.
- rd_addr_o  out  5  register address of the read.
- rd_data_i  in  16  read data; sampled in the cycle after rd_req_o.
- frame_err_o  out  1  one-cycle pulse on a bad ST/OP/TA pattern.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, preamble count 0, shift registers 0.
- Sync and edges: mdc_i and mdio_i pass through SyncStages flops. A rising MDC edge is detected when the synced MDC is 1 and its previous value was 0. All bit sampling and all drive updates happen only in cycles with a detected rising edge ("edge").

FSM states and transitions (each bit is taken at an edge):
- IDLE: bit 1 increments the preamble count, saturating at PreambleLen. Bit 0 with count >= PreambleLen goes to ST2. Bit 0 with a short count resets the count and stays in IDLE.
- ST2: bit 1 goes to OP. Bit 0 pulses frame_err_o, returns to IDLE, count 0.
- OP: two bits. 10 = read, 01 = write, others pulse frame_err_o and return to IDLE. Go to PHYAD.
- PHYAD: five bits, MSB first, then REGAD. A mismatch against phy_addr_i (compared after the 5th bit) returns silently to IDLE with count 0. No frame_err_o.
- REGAD: five bits, MSB first.
  - Read: on the 5th bit's edge, pulse rd_req_o with rd_addr_o = REGAD. Capture rd_data_i into the TX shift register on the next clk cycle. Go to TA.
  - Write: go to TA.
- TA, read:
  - Edge 1 after REGAD: set mdio_oe_o=1, mdio_o=0.
  - Each of the next 16 edges: drive data[15] down to data[0].
  - The edge after data[0]: mdio_oe_o=0, go to IDLE with count 0.
- TA, write: the two sampled bits must be 10. Otherwise pulse frame_err_o and return to IDLE. Go to WDATA.
- WDATA: 16 bits, MSB first. On the 16th bit's edge, in the same cycle, pulse wr_valid_o with wr_addr_o/wr_data_o.
- wr_addr_o, wr_data_o and rd_addr_o hold their values until the next transaction.

Boundary rules:
- A bus level that never reaches 0 leaves the FSM in IDLE.
- rd_req_o and wr_valid_o are never asserted in the same cycle.
- Back-to-back frames are supported: the next frame needs its own preamble, and preamble counting starts in the edge after the return to IDLE.
- rst_i mid-frame: mdio_oe_o drops asynchronously and no strobe is issued.
- phy_addr_i changes are honoured at the next PHYAD compare.
- mdio_oe_o is never 1 outside a read frame addressed to this PHY.

Test Plan:
- Write, PHY 5'h01, REG 5'h04, data 16'h01E1, 32-bit preamble -> exactly one wr_valid_o pulse, wr_addr_o=4, wr_data_o=16'h01E1; mdio_oe_o stays 0 throughout.
- Read, PHY 5'h01, REG 5'h02, rd_data_i=16'h0141 -> one rd_req_o with rd_addr_o=2; MAC samples TA2=0, then 0000_0001_0100_0001; mdio_oe_o deasserts after bit 0.
- Read to PHY 5'h03 with phy_addr_i=5'h01 -> no rd_req_o, mdio_oe_o never 1, no frame_err_o; a following valid write to 5'h01 is accepted.
- Only 31 preamble ones, then a valid write -> ignored (no wr_valid_o). Same frame with 40 ones -> accepted.
- Write with TA=11 -> one frame_err_o pulse, no wr_valid_o. OP=11 -> frame_err_o, FSM back in IDLE.
- rst_i asserted during the 8th read data bit -> mdio_oe_o=0 immediately. After release, a fresh read of REG 2 returns the correct data.

Source files
------------

// File: rtl/eth_mdio_responder.sv
// Clause-22 MDIO responder (PHY side): oversamples MDC, decodes frames addressed to this PHY
// and bridges them onto a single-cycle local register read/write port.
module eth_mdio_responder #(
  parameter int unsigned SyncStages  = 3,
  parameter int unsigned PreambleLen = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  phy_addr_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  output logic        wr_valid_o,
  output logic [4:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        rd_req_o,
  output logic [4:0]  rd_addr_o,
  input  logic [15:0] rd_data_i,
  output logic        frame_err_o
);

  typedef enum logic [2:0] {
    StIdle, StSt2, StOp, StPhy, StReg, StTa, StWdata, StRdata
  } state_e;

  localparam logic [5:0] PreLen = 6'(PreambleLen);

  state_e          state_q, state_d;
  logic [SyncStages-1:0] mdc_sync_q, mdio_sync_q;
  logic            mdc_prev_q;
  logic [4:0]      cnt_q, cnt_d;
  logic [5:0]      pre_q, pre_d;
  logic [15:0]     sh_q, sh_d, sh_next;
  logic            is_rd_q, is_rd_d;
  logic [4:0]      regad_q, regad_d;
  logic [15:0]     tx_q, tx_d;
  logic            cap_q;
  logic            mdio_o_q, mdio_o_d, mdio_oe_q, mdio_oe_d;
  logic            wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, frame_err_q, frame_err_d;
  logic [4:0]      wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            mdc_rise, bit_in, op_read, op_write, ta_ok;

  assign mdc_rise = mdc_sync_q[SyncStages-1] & ~mdc_prev_q;
  assign bit_in   = mdio_sync_q[SyncStages-1];
  assign sh_next  = {sh_q[14:0], bit_in};
  assign op_read  = (sh_next[1:0] == 2'b10);
  assign op_write = (sh_next[1:0] == 2'b01);
  assign ta_ok    = (sh_next[1:0] == 2'b10);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      pre_q       <= '0;
      sh_q        <= '0;
      is_rd_q     <= 1'b0;
      regad_q     <= '0;
      tx_q        <= '0;
      cap_q       <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_oe_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SyncStages-2:0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[SyncStages-2:0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[SyncStages-1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      sh_q        <= sh_d;
      is_rd_q     <= is_rd_d;
      regad_q     <= regad_d;
      tx_q        <= tx_d;
      cap_q       <= rd_req_q;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  // cnt_q counts bits within the current field; it is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    sh_d    = sh_q;
    is_rd_d = is_rd_q;
    if (mdc_rise) begin
      sh_d  = sh_next;
      cnt_d = cnt_q + 5'd1;
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (bit_in) begin
            if (pre_q < PreLen) pre_d = pre_q + 6'd1;
          end else begin
            if (pre_q >= PreLen) state_d = StSt2;
            pre_d = '0;
          end
        end
        StSt2: begin
          cnt_d   = '0;
          state_d = bit_in ? StOp : StIdle;
        end
        StOp: if (cnt_q == 5'd1) begin
          cnt_d   = '0;
          is_rd_d = op_read;
          state_d = (op_read || op_write) ? StPhy : StIdle;
        end
        StPhy: if (cnt_q == 5'd4) begin
          cnt_d   = '0;
          state_d = (sh_next[4:0] == phy_addr_i) ? StReg : StIdle;
        end
        StReg: if (cnt_q == 5'd4) begin
          cnt_d   = '0;
          state_d = StTa;
        end
        StTa: begin
          if (is_rd_q) begin
            cnt_d   = '0;
            state_d = StRdata;
          end else if (cnt_q == 5'd1) begin
            cnt_d   = '0;
            state_d = ta_ok ? StWdata : StIdle;
          end
        end
        StWdata: if (cnt_q == 5'd15) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
        StRdata: if (cnt_q == 5'd16) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;
    frame_err_d = 1'b0;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    regad_d     = regad_q;
    tx_d        = tx_q;
    // Read data is taken one cycle after the request strobe, long before the first data edge.
    if (cap_q) tx_d = rd_data_i;
    if (mdc_rise) begin
      case (state_q)
        StSt2: frame_err_d = ~bit_in;
        StOp: if (cnt_q == 5'd1 && !(op_read || op_write)) frame_err_d = 1'b1;
        StReg: if (cnt_q == 5'd4) begin
          regad_d = sh_next[4:0];
          if (is_rd_q) begin
            rd_req_d  = 1'b1;
            rd_addr_d = sh_next[4:0];
          end
        end
        StTa: begin
          if (is_rd_q) begin
            mdio_oe_d = 1'b1;
            mdio_o_d  = 1'b0;
          end else if (cnt_q == 5'd1 && !ta_ok) begin
            frame_err_d = 1'b1;
          end
        end
        StWdata: if (cnt_q == 5'd15) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = regad_q;
          wr_data_d  = sh_next;
        end
        StRdata: begin
          if (cnt_q == 5'd16) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b0;
          end else begin
            mdio_o_d = tx_q[15];
            tx_d     = {tx_q[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign mdio_o      = mdio_o_q;
  assign mdio_oe_o   = mdio_oe_q;
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rd_req_o    = rd_req_q;
  assign rd_addr_o   = rd_addr_q;
  assign frame_err_o = frame_err_q;

endmodule
